// File: rtl/gpu_raster_ctrl.sv
// Raster timing generator with layer priority mixer, border fill and a small
// register block (status/ctrl/line compare/border) driving a level interrupt.
// BORDER holds up to 8 bits, so COLOR_BITS is expected to be at most 2.
module gpu_raster_ctrl #(
    parameter int H_VISIBLE   = 320,
    parameter int H_FP        = 8,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 24,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int X_OFFSET    = 32,
    parameter int DRAW_W      = 256,
    parameter int DRAW_H      = 240,
    parameter int LINE_REPEAT = 2,
    parameter int NUM_LAYERS  = 2,
    parameter int COLOR_BITS  = 2
) (
    input  logic                               clk_12_5875,
    input  logic                               rst,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]              layer_valid,
    output logic [COLOR_BITS-1:0]              r,
    output logic [COLOR_BITS-1:0]              g,
    output logic [COLOR_BITS-1:0]              b,
    output logic                               hsync,
    output logic                               vsync,
    output logic [8:0]                         current_x,
    output logic [8:0]                         current_y,
    output logic                               vram_writable,
    output logic                               controller_start_fetch,
    input  logic                               reg_sel,
    input  logic                               reg_we,
    input  logic [1:0]                         reg_addr,
    input  logic [7:0]                         reg_wdata,
    output logic [7:0]                         reg_rdata,
    output logic                               irq
);
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL + 1);
    localparam int VW       = $clog2(V_TOTAL + 1);
    localparam int CW       = 3 * COLOR_BITS;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;
    logic                  vblank_pend_q, vblank_pend_d;
    logic                  line_pend_q, line_pend_d;
    logic                  vblank_ie_q, vblank_ie_d;
    logic                  line_ie_q, line_ie_d;
    logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
    logic [7:0]            line_cmp_q, line_cmp_d;
    logic [CW-1:0]         border_q, border_d;
    logic [CW-1:0]         rgb_q, rgb_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  irq_q, irq_d;

    logic                  visible, drawing, wr, vblank_evt, line_evt;
    logic [CW-1:0]         layer_col;

    assign current_x              = 9'(hcnt_q) - 9'(X_OFFSET);
    assign current_y              = 9'(vcnt_q / VW'(LINE_REPEAT));
    assign vram_writable          = vcnt_q >= VW'(V_VISIBLE);
    assign controller_start_fetch = (16'(hcnt_q) < 16'd32) && (vcnt_q == '0);
    assign visible                = (hcnt_q < HW'(H_VISIBLE)) && (vcnt_q < VW'(V_VISIBLE));
    assign drawing                = visible && (current_x < 9'(DRAW_W)) && (current_y < 9'(DRAW_H));
    assign wr                     = reg_sel && reg_we;
    assign vblank_evt             = (hcnt_q == '0) && (vcnt_q == VW'(V_VISIBLE));
    // Out-of-range compare values can never match a visible line, so gate them off.
    assign line_evt               = (hcnt_q == '0)
                                 && (16'(line_cmp_q) < 16'(V_VISIBLE / LINE_REPEAT))
                                 && (16'(vcnt_q) == 16'(line_cmp_q) * 16'(LINE_REPEAT));

    assign {r, g, b} = rgb_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign irq       = irq_q;

    // Beam counters: horizontal wraps every line and steps the vertical counter.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Pixel colour: lowest enabled valid layer wins, top layer is the backdrop.
    always_comb begin
        layer_col = layer_rgb[(NUM_LAYERS-1)*CW +: CW];
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_valid[i] && layer_en_q[i]) layer_col = layer_rgb[i*CW +: CW];
        end
        rgb_d   = !visible ? '0 : (!drawing ? border_q : layer_col);
        hsync_d = !((hcnt_q >= HW'(HS_START)) && (hcnt_q < HW'(HS_END)));
        vsync_d = !((vcnt_q >= VW'(VS_START)) && (vcnt_q < VW'(VS_END)));
    end

    // Register writes and pend bits; a set event beats a same-cycle W1C.
    always_comb begin
        vblank_ie_d = vblank_ie_q;
        line_ie_d   = line_ie_q;
        layer_en_d  = layer_en_q;
        line_cmp_d  = line_cmp_q;
        border_d    = border_q;
        if (wr) begin
            case (reg_addr)
                2'd1: begin
                    vblank_ie_d = reg_wdata[0];
                    line_ie_d   = reg_wdata[1];
                    layer_en_d  = reg_wdata[4 +: NUM_LAYERS];
                end
                2'd2:    line_cmp_d = reg_wdata;
                2'd3:    border_d   = reg_wdata[CW-1:0];
                default: ;
            endcase
        end
        vblank_pend_d = (vblank_pend_q && !(wr && reg_addr == 2'd0 && reg_wdata[1])) || vblank_evt;
        line_pend_d   = (line_pend_q && !(wr && reg_addr == 2'd0 && reg_wdata[2])) || line_evt;
        irq_d         = (vblank_pend_q && vblank_ie_q) || (line_pend_q && line_ie_q);
    end

    // Combinational read mux; unimplemented bits read 0.
    always_comb begin
        reg_rdata = 8'h00;
        if (reg_sel) begin
            case (reg_addr)
                2'd0: reg_rdata = {5'b0, line_pend_q, vblank_pend_q, vram_writable};
                2'd1: begin
                    reg_rdata[0]               = vblank_ie_q;
                    reg_rdata[1]               = line_ie_q;
                    reg_rdata[4 +: NUM_LAYERS] = layer_en_q;
                end
                2'd2:    reg_rdata = line_cmp_q;
                default: reg_rdata[CW-1:0] = border_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            vblank_pend_q <= 1'b0;
            line_pend_q   <= 1'b0;
            vblank_ie_q   <= 1'b0;
            line_ie_q     <= 1'b0;
            layer_en_q    <= '1;
            line_cmp_q    <= '0;
            border_q      <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            irq_q         <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            vblank_pend_q <= vblank_pend_d;
            line_pend_q   <= line_pend_d;
            vblank_ie_q   <= vblank_ie_d;
            line_ie_q     <= line_ie_d;
            layer_en_q    <= layer_en_d;
            line_cmp_q    <= line_cmp_d;
            border_q      <= border_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            irq_q         <= irq_d;
        end
    end
endmodule

// File: tb/tb_gpu_raster_ctrl.sv
// Bench for gpu_raster_ctrl on a shrunken raster (56 x 38 clocks per frame).
// A behavioural model predicts each cycle's registered outputs; predictions
// are queued before the edge and popped against the DUT after it.
module tb_gpu_raster_ctrl;
    localparam int HV = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 30, VFP = 2, VS = 2, VBP = 4;
    localparam int XO = 4, DW = 24, DH = 12, LR = 2, NL = 2, CB = 2;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NL*3*CB-1:0] layer_rgb = '0;
    logic [NL-1:0] layer_valid = '0;
    logic [CB-1:0] r, g, b;
    logic hsync, vsync, vram_writable, controller_start_fetch, irq;
    logic [8:0] current_x, current_y;
    logic reg_sel = 1'b0, reg_we = 1'b0;
    logic [1:0] reg_addr = '0;
    logic [7:0] reg_wdata = '0;
    logic [7:0] reg_rdata;

    gpu_raster_ctrl #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .X_OFFSET(XO), .DRAW_W(DW), .DRAW_H(DH), .LINE_REPEAT(LR),
        .NUM_LAYERS(NL), .COLOR_BITS(CB)
    ) dut (
        .clk_12_5875(clk), .rst(rst), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .current_x(current_x), .current_y(current_y), .vram_writable(vram_writable),
        .controller_start_fetch(controller_start_fetch), .reg_sel(reg_sel), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    exp_t sb[$];
    // model state
    int mhc = 0, mvc = 0, mcmp = 0;
    bit mvpend = 0, mlpend = 0, mvie = 0, mlie = 0, mirq = 0, rnd = 1;
    logic [1:0] men = 2'b11;
    logic [5:0] mbord = '0;
    // sync statistics
    int cyc = 0, hs_low = 0, vs_low = 0, last_fall = -1, period = -1;
    bit prev_vs = 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (h=%0d v=%0d)", tag, act, exp, mhc, mvc);
        end
    endtask

    function automatic logic [5:0] exp_pix();
        int cx, cy, sel;
        bit vis, drw;
        vis = (mhc < HV) && (mvc < VV);
        cx  = (mhc - XO) & 511;
        cy  = mvc / LR;
        drw = vis && (cx < DW) && (cy < DH);
        if (!vis) return 6'h00;
        if (!drw) return mbord;
        sel = NL - 1;
        for (int i = NL - 1; i >= 0; i--) if (layer_valid[i] && men[i]) sel = i;
        return layer_rgb[sel*6 +: 6];
    endfunction

    task automatic tick();
        exp_t e;
        bit w, ve, le;
        if (rnd) begin
            layer_rgb   = 12'($urandom);
            layer_valid = 2'($urandom);
        end
        e.rgb = rst ? 6'h00 : exp_pix();
        e.hs  = rst ? 1'b1 : !(mhc >= HV + HFP && mhc < HV + HFP + HS);
        e.vs  = rst ? 1'b1 : !(mvc >= VV + VFP && mvc < VV + VFP + VS);
        e.irq = rst ? 1'b0 : ((mvpend && mvie) || (mlpend && mlie));
        sb.push_back(e);
        w  = reg_sel && reg_we;
        ve = (mhc == 0) && (mvc == VV);
        le = (mhc == 0) && (mcmp < VV / LR) && (mvc == mcmp * LR);
        @(posedge clk);
        #1;
        if (rst) begin
            mhc = 0; mvc = 0; mvpend = 0; mlpend = 0; mvie = 0; mlie = 0;
            men = 2'b11; mcmp = 0; mbord = '0;
        end else begin
            mvpend = (mvpend && !(w && reg_addr == 0 && reg_wdata[1])) || ve;
            mlpend = (mlpend && !(w && reg_addr == 0 && reg_wdata[2])) || le;
            if (w) begin
                case (reg_addr)
                    2'd1: begin mvie = reg_wdata[0]; mlie = reg_wdata[1]; men = reg_wdata[5:4]; end
                    2'd2: mcmp = int'(reg_wdata);
                    2'd3: mbord = reg_wdata[5:0];
                    default: ;
                endcase
            end
            mhc = mhc + 1;
            if (mhc == HT) begin
                mhc = 0;
                mvc = (mvc == VT - 1) ? 0 : mvc + 1;
            end
        end
        e = sb.pop_front();
        chk("pix", 32'({r, g, b, hsync, vsync, irq}), 32'({e.rgb, e.hs, e.vs, e.irq}));
        chk("coord", 32'({current_x, current_y, vram_writable, controller_start_fetch}),
            32'({9'((mhc - XO) & 511), 9'(mvc / LR), 1'(mvc >= VV), 1'((mhc < 32) && (mvc == 0))}));
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (prev_vs && !vsync) begin
            if (last_fall >= 0) period = cyc - last_fall;
            last_fall = cyc;
        end
        prev_vs = vsync;
        cyc++;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_sel = 1'b0; reg_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
        #1;
        chk(tag, 32'(reg_rdata), 32'(exp));
        reg_sel = 1'b0;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(mhc == h && mvc == v) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        chk("run_to", 32'(mhc * 1000 + mvc), 32'(h * 1000 + v));
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        rd_chk("rst_status", 2'd0, 8'h00);
        rd_chk("rst_ctrl", 2'd1, 8'h30);
        rd_chk("rst_cmp", 2'd2, 8'h00);
        rd_chk("rst_border", 2'd3, 8'h00);
        chk("rst_out", 32'({r, g, b, hsync, vsync, irq}), 32'({6'h00, 1'b1, 1'b1, 1'b0}));
        rst = 1'b0;
        #1;
        chk("rdata_nosel", 32'(reg_rdata), 32'h0);

        // Two frames of timing with random layer data
        wr_reg(2'd3, 8'h2D);
        wr_reg(2'd1, 8'h10);
        hs_low = 0; vs_low = 0; last_fall = -1; period = -1;
        repeat (2 * FRAME) tick();
        chk("hsync_low", 32'(hs_low), 32'(2 * VT * HS));
        chk("vsync_low", 32'(vs_low), 32'(2 * VS * HT));
        chk("frame_len", 32'(period), 32'(FRAME));

        // Priority: both valid, only layer 1 enabled
        rnd = 0;
        layer_valid = 2'b11;
        layer_rgb   = {6'h2A, 6'h15};
        wr_reg(2'd1, 8'h20);
        run_to(XO + DW - 1, 2);
        tick();
        chk("last_drawn_l1", 32'({r, g, b}), 32'h2A);
        tick();
        chk("x_dw_border", 32'({r, g, b}), 32'h2D);
        run_to(HV + 2, 2);
        tick();
        chk("hblank_black", 32'({r, g, b}), 32'h00);
        run_to(XO + 3, 2 * DH);
        tick();
        chk("y_dh_border", 32'({r, g, b}), 32'h2D);
        rnd = 1;

        // Vblank interrupt and W1C
        wr_reg(2'd0, 8'h06);
        wr_reg(2'd1, 8'h01);
        run_to(0, VV);
        tick();
        rd_chk("vbl_pend_set", 2'd0, 8'h03);
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_vbl", 32'(irq), 32'h1);
        wr_reg(2'd0, 8'h02);
        rd_chk("vbl_cleared", 2'd0, 8'h01);
        tick();
        chk("irq_clr", 32'(irq), 32'h0);

        // Line compare
        wr_reg(2'd2, 8'd5);
        wr_reg(2'd1, 8'h02);
        wr_reg(2'd0, 8'h06);
        run_to(0, 5 * LR);
        rd_chk("line_before", 2'd0, 8'h00);
        tick();
        rd_chk("line_set", 2'd0, 8'h04);
        tick();
        chk("irq_line", 32'(irq), 32'h1);
        wr_reg(2'd2, 8'(VV / LR));
        wr_reg(2'd0, 8'h06);
        repeat (FRAME + HT) tick();
        rd_chk("line_oob", 2'd0, {5'b0, 1'b0, 1'(mvpend), 1'(mvc >= VV)});
        chk("line_oob_pend", 32'(dut.line_pend_q), 32'h0);

        // Set beats clear on collision
        wr_reg(2'd0, 8'h06);
        run_to(0, VV);
        wr_reg(2'd0, 8'h02);
        rd_chk("w1c_collide", 2'd0, 8'h03);

        // Mid-frame reset with pends and irq active
        wr_reg(2'd2, 8'd3);
        wr_reg(2'd1, 8'h03);
        run_to(0, 20);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_xy", 32'({current_x, current_y}), 32'({9'((0 - XO) & 511), 9'd0}));
        rd_chk("mid_rst_status", 2'd0, 8'h00);
        rd_chk("mid_rst_ctrl", 2'd1, 8'h30);
        repeat (HT) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/gpu_raster_ctrl.md
GPU_RASTER_CTRL -- requirements
Module: gpu_raster_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_VISIBLE, 320, visible pixels per line
- H_FP, 8, horizontal front porch
- H_SYNC, 48, hsync width
- H_BP, 24, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- X_OFFSET, 32, hcounter of logical x=0
- DRAW_W, 256, drawn width
- DRAW_H, 240, drawn height
- LINE_REPEAT, 2, physical lines per logical line (1,2,4)
- NUM_LAYERS, 2, layers mixed (1..4)
- COLOR_BITS, 2, bits per channel

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_12_5875, in, 1, pixel clock
- rst, in, 1, reset: synchronous, active-high
- layer_rgb, in, NUM_LAYERS*3*COLOR_BITS, per-layer {r,g,b}; layer 0 in LSBs
- layer_valid, in, NUM_LAYERS, layer pixel opaque
- r, g, b, out, COLOR_BITS each, registered colour
- hsync, vsync, out, 1 each, active-low, registered
- current_x, current_y, out, 9 each, logical coordinates
- vram_writable, out, 1, vertical blanking active
- controller_start_fetch, out, 1, controller poll window
- reg_sel, reg_we, in, 1 each, register select / write strobe
- reg_addr, in, 2, register index
- reg_wdata, in, 8, write data
- reg_rdata, out, 8, combinational read data; 0 when reg_sel=0
- irq, out, 1, registered interrupt, active-high

Function
REQ-003 SHALL keep hcounter 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrap to 0, and on wrap step vcounter 0..V_TOTAL-1 with wrap to 0.
REQ-004 SHALL set visible = hcounter<H_VISIBLE && vcounter<V_VISIBLE.
REQ-005 SHALL assert hsync low for hcounter in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC); same rule applies to vsync with the V parameters.
REQ-006 SHALL drive current_x = hcounter - X_OFFSET mod 512 and current_y = vcounter / LINE_REPEAT, both combinational from the counters.
REQ-007 SHALL set drawing = visible && current_x<DRAW_W && current_y<DRAW_H.
REQ-008 SHALL pick the colour by priority: the lowest-index layer i with layer_valid[i] && LAYER_EN[i]; if no layer qualifies, use layer NUM_LAYERS-1 (backdrop).
REQ-009 SHALL output BORDER colour when visible && !drawing, and 0 when !visible.
REQ-010 SHALL register r, g, b, hsync and vsync; all five have 1-cycle latency from the counter state.
REQ-011 SHALL drive vram_writable = vcounter>=V_VISIBLE, combinational.
REQ-012 SHALL drive controller_start_fetch = hcounter<32 && vcounter==0.
REQ-013 Register map SHALL be:
- 0 STATUS: read {5'b0, line_pend, vblank_pend, vram_writable}; write-1-to-clear bits 2:1.
- 1 CTRL: bit0 VBLANK_IE, bit1 LINE_IE, bits[4+NUM_LAYERS-1:4] LAYER_EN.
- 2 LINE_CMP: 8-bit logical line.
- 3 BORDER: bits[3*COLOR_BITS-1:0].
- Unimplemented bits read 0.
REQ-014 SHALL set vblank_pend in the cycle where hcounter==0 && vcounter==V_VISIBLE.
REQ-015 SHALL set line_pend in the cycle where hcounter==0 && vcounter==LINE_CMP*LINE_REPEAT; a LINE_CMP >= V_VISIBLE/LINE_REPEAT never fires.
REQ-016 SHALL give set priority over a W1C clear in the same cycle, so no event is lost.
REQ-017 SHALL register irq = (vblank_pend&VBLANK_IE)|(line_pend&LINE_IE), one cycle after the pend/enable change.
REQ-018 SHALL take register writes when reg_sel&&reg_we at the clock edge, in any counter state.

Reset
REQ-019 On rst SHALL set:
- hcounter, vcounter, pend bits and irq = 0
- CTRL = LAYER_EN all-ones, IEs 0
- LINE_CMP = 0, BORDER = 0
- r, g, b = 0; hsync, vsync = 1
REQ-020 rst asserted mid-frame SHALL restart the frame at (0,0) on the next edge; no stale pend survives.

Verification
REQ-021 Run 2 frames after reset -> hsync low 48 clk per 400-clk line; vsync low lines 490-491; frame = 210000 clk.
REQ-022 Set layer_valid=2'b11, LAYER_EN=2'b10 -> output = layer1 colour. At hcounter=32+256 (x=256) -> BORDER colour. At hcounter=330 -> 0.
REQ-023 Set CTRL=0x01; at vcounter=480 -> irq=1 one cycle after vblank_pend. Write STATUS=0x02 -> irq=0 next cycle.
REQ-024 Set LINE_CMP=100, LINE_IE=1 -> line_pend set at vcounter=200, hcounter=0. LINE_CMP=250 -> never set.
REQ-025 Issue a W1C of vblank_pend in the same cycle as the vblank set event -> vblank_pend stays 1.
REQ-026 Assert rst at vcounter=300 with pends set -> counters, pends and irq = 0 next cycle; CTRL returns to its reset value.
